// File: rtl/mesh_frame_sequencer.sv
// Streams ROWS pixel rows into a compute mesh, then settles, evaluates and captures the mesh result.
// Optional MESH_SEQ_FRAME_CNT_EN adds a 16-bit count of delivered results (frame_cnt).
module mesh_frame_sequencer #(
  parameter int ROWS       = 18,
  parameter int COLS       = 26,
  parameter int BPP        = 2,
  parameter int SETTLE_CYC = 1,
  parameter int EVAL_CYC   = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [COLS*BPP-1:0]    s_row_data,
  input  logic                   s_row_valid,
  output logic                   s_row_ready,
  output logic [COLS*BPP-1:0]    m_inp,
  output logic [4:0]             m_row,
  output logic                   m_high,
  input  logic [ROWS*COLS-1:0]   m_out,
  output logic [ROWS*COLS-1:0]   res_data,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic                   busy
`ifdef MESH_SEQ_FRAME_CNT_EN
  ,
  output logic [15:0]            frame_cnt
`endif
);

  typedef enum logic [1:0] {LOAD, SETTLE, EVAL} state_t;

  localparam logic [4:0] ROW_LAST    = 5'(ROWS - 1);
  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYC - 1);
  localparam logic [7:0] EVAL_LAST   = 8'(EVAL_CYC - 1);

  state_t                 state_q, state_d;
  logic [4:0]             row_cnt_q, row_cnt_d;
  logic [7:0]             phase_cnt_q, phase_cnt_d;
  logic [COLS*BPP-1:0]    m_inp_q, m_inp_d;
  logic [4:0]             m_row_q, m_row_d;
  logic [ROWS*COLS-1:0]   res_data_q, res_data_d;
  logic                   res_valid_q, res_valid_d;
  logic                   slot_busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= LOAD;
      row_cnt_q   <= '0;
      phase_cnt_q <= '0;
      m_inp_q     <= '0;
      m_row_q     <= '0;
      res_data_q  <= '0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_cnt_q   <= row_cnt_d;
      phase_cnt_q <= phase_cnt_d;
      m_inp_q     <= m_inp_d;
      m_row_q     <= m_row_d;
      res_data_q  <= res_data_d;
      res_valid_q <= res_valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    row_cnt_d   = row_cnt_q;
    phase_cnt_d = phase_cnt_q;
    m_inp_d     = m_inp_q;
    m_row_d     = m_row_q;
    res_data_d  = res_data_q;
    res_valid_d = res_valid_q;
    slot_busy   = res_valid_q & ~res_ready;

    // A release and a fresh capture on the same edge leave res_valid set.
    if (res_valid_q && res_ready) begin
      res_valid_d = 1'b0;
    end

    case (state_q)
      LOAD: begin
        if (s_row_valid) begin
          m_inp_d = s_row_data;
          m_row_d = row_cnt_q;
          if (row_cnt_q == ROW_LAST) begin
            row_cnt_d   = '0;
            phase_cnt_d = '0;
            state_d     = SETTLE;
          end else begin
            row_cnt_d = row_cnt_q + 5'd1;
          end
        end
      end
      SETTLE: begin
        // Evaluation waits here until the previous result has been taken.
        if (phase_cnt_q < SETTLE_LAST) begin
          phase_cnt_d = phase_cnt_q + 8'd1;
        end else if (!slot_busy) begin
          phase_cnt_d = '0;
          state_d     = EVAL;
        end
      end
      EVAL: begin
        if (phase_cnt_q == EVAL_LAST) begin
          res_data_d  = m_out;
          res_valid_d = 1'b1;
          phase_cnt_d = '0;
          state_d     = LOAD;
        end else begin
          phase_cnt_d = phase_cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = LOAD;
      end
    endcase
  end

  assign s_row_ready = (state_q == LOAD);
  assign m_high      = (state_q == EVAL);
  assign busy        = (state_q != LOAD) | (row_cnt_q != 5'd0);
  assign m_inp       = m_inp_q;
  assign m_row       = m_row_q;
  assign res_data    = res_data_q;
  assign res_valid   = res_valid_q;

`ifdef MESH_SEQ_FRAME_CNT_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (res_valid_q && res_ready) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt_q <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_mesh_frame_sequencer.sv
// Randomized self-checking bench for mesh_frame_sequencer against a frame-level reference model.
// Emulates the mesh: each row latches "pixel nonzero" bits; m_out is only correct while m_high.
module tb_mesh_frame_sequencer;

  localparam int ROWS       = 18;
  localparam int COLS       = 26;
  localparam int BPP        = 2;
  localparam int SETTLE_CYC = 1;
  localparam int EVAL_CYC   = 4;
  localparam int RW         = COLS * BPP;
  localparam int MW         = ROWS * COLS;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [RW-1:0]   s_row_data = '0;
  logic            s_row_valid = 1'b0;
  logic            s_row_ready;
  logic [RW-1:0]   m_inp;
  logic [4:0]      m_row;
  logic            m_high;
  logic [MW-1:0]   m_out;
  logic [MW-1:0]   res_data;
  logic            res_valid;
  logic            res_ready = 1'b1;
  logic            busy;
`ifdef MESH_SEQ_FRAME_CNT_EN
  logic [15:0]     frame_cnt;
`endif

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;
  bit rand_ready = 1'b0;
  bit fc_chk = 1'b1;
  bit preload_req = 1'b0;

  mesh_frame_sequencer #(
    .ROWS(ROWS), .COLS(COLS), .BPP(BPP), .SETTLE_CYC(SETTLE_CYC), .EVAL_CYC(EVAL_CYC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .s_row_data(s_row_data),
    .s_row_valid(s_row_valid),
    .s_row_ready(s_row_ready),
    .m_inp(m_inp),
    .m_row(m_row),
    .m_high(m_high),
    .m_out(m_out),
    .res_data(res_data),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .busy(busy)
`ifdef MESH_SEQ_FRAME_CNT_EN
    ,
    .frame_cnt(frame_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [COLS-1:0] reduceRow(input logic [RW-1:0] d);
    logic [COLS-1:0] r;
    for (int c = 0; c < COLS; c++) r[c] = (d[c*BPP +: BPP] != '0);
    return r;
  endfunction

  // Mesh emulation: the addressed row continuously follows m_inp.
  logic [COLS-1:0] mesh [ROWS];
  logic [MW-1:0]   mesh_flat;
  initial for (int r = 0; r < ROWS; r++) mesh[r] = '0;
  always @(posedge clk) if (int'(m_row) < ROWS) mesh[m_row] <= reduceRow(m_inp);
  always_comb begin
    mesh_flat = '0;
    for (int r = 0; r < ROWS; r++) mesh_flat[r*COLS +: COLS] = mesh[r];
    m_out = m_high ? mesh_flat : ~mesh_flat;
  end

  // Reference model: tracks frames, settle/eval durations and the result slot.
  int            mdl_rows;
  bit            mdl_framing, mdl_eval;
  int            mdl_settle, mdl_evcnt;
  logic [RW-1:0] mdl_frame [ROWS];
  logic [RW-1:0] exp_m_inp;
  logic [4:0]    exp_m_row;
  logic          exp_res_valid;
  logic [MW-1:0] exp_res_data;
  logic [15:0]   exp_fc;

  function automatic logic [MW-1:0] frameResult();
    logic [MW-1:0] v;
    for (int r = 0; r < ROWS; r++) v[r*COLS +: COLS] = reduceRow(mdl_frame[r]);
    return v;
  endfunction

  always @(posedge clk) begin : model
    bit rel, slot, new_res;
    if (rst) begin
      mdl_rows = 0; mdl_framing = 0; mdl_eval = 0; mdl_settle = 0; mdl_evcnt = 0;
      exp_m_inp = '0; exp_m_row = '0; exp_res_valid = 0; exp_res_data = '0; exp_fc = '0;
    end else begin
      rel = exp_res_valid && res_ready;
      slot = exp_res_valid && !res_ready;
      new_res = 0;
      if (!mdl_framing) begin
        if (s_row_valid) begin
          exp_m_inp = s_row_data;
          exp_m_row = 5'(mdl_rows);
          mdl_frame[mdl_rows] = s_row_data;
          mdl_rows++;
          if (mdl_rows == ROWS) begin
            mdl_rows = 0; mdl_framing = 1; mdl_eval = 0; mdl_settle = 0;
          end
        end
      end else if (!mdl_eval) begin
        mdl_settle++;
        if (mdl_settle >= SETTLE_CYC && !slot) begin
          mdl_eval = 1; mdl_evcnt = 0;
        end
      end else begin
        mdl_evcnt++;
        if (mdl_evcnt == EVAL_CYC) begin
          new_res = 1; mdl_framing = 0; mdl_eval = 0;
          exp_res_data = frameResult();
        end
      end
      if (preload_req) exp_fc = 16'hFFFF;
      else if (rel) exp_fc = exp_fc + 16'd1;
      if (new_res) exp_res_valid = 1;
      else if (rel) exp_res_valid = 0;
    end
  end

  task automatic checkOutput(input string name, input logic [MW-1:0] act, input logic [MW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin : compare
    if (cmp_en) begin
      checkOutput("s_row_ready", MW'(s_row_ready), MW'(!mdl_framing));
      checkOutput("m_high", MW'(m_high), MW'(mdl_framing && mdl_eval));
      checkOutput("busy", MW'(busy), MW'(mdl_framing || mdl_rows != 0));
      checkOutput("m_inp", MW'(m_inp), MW'(exp_m_inp));
      checkOutput("m_row", MW'(m_row), MW'(exp_m_row));
      checkOutput("res_valid", MW'(res_valid), MW'(exp_res_valid));
      checkOutput("res_data", res_data, exp_res_data);
`ifdef MESH_SEQ_FRAME_CNT_EN
      if (fc_chk) checkOutput("frame_cnt", MW'(frame_cnt), MW'(exp_fc));
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) res_ready = 1'($urandom_range(0, 1));
  endtask

  function automatic logic [RW-1:0] randRow();
    logic [63:0] w;
    w = {$urandom, $urandom};
    return w[RW-1:0];
  endfunction

  function automatic logic [RW-1:0] patRow(input int i);
    logic [BPP-1:0] pats [6];
    logic [RW-1:0]  d;
    pats[0] = 2'b01; pats[1] = 2'b00; pats[2] = 2'b10;
    pats[3] = 2'b10; pats[4] = 2'b01; pats[5] = 2'b11;
    for (int c = 0; c < COLS; c++) d[c*BPP +: BPP] = pats[i % 6];
    return d;
  endfunction

  // Presents one row, waits (bounded) for acceptance, then idles with garbage data for gap cycles.
  task automatic applyStimulus(input logic [RW-1:0] d, input int gap);
    bit acc;
    acc = 0;
    s_row_valid = 1'b1;
    s_row_data = d;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      acc = s_row_ready;
      tick();
      if (acc) break;
    end
    if (!acc) checkOutput("accept_timeout", 1, 0);
    s_row_valid = 1'b0;
    s_row_data = randRow();
    repeat (gap) tick();
  endtask

  task automatic waitResult(output int cyc);
    cyc = -1;
    for (int n = 1; n <= 300; n++) begin
      tick();
      if (res_valid) begin
        cyc = n;
        break;
      end
    end
    if (cyc < 0) checkOutput("result_timeout", 1, 0);
  endtask

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin : stimulus
    logic [MW-1:0] res_a, res_b;
    int cyc, high, first_high;

    rst = 1'b1;
    tick();
    cmp_en = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("reset_busy", MW'(busy), 0);
    checkOutput("reset_res_valid", MW'(res_valid), 0);
    checkOutput("reset_m_row", MW'(m_row), 0);
    checkOutput("reset_m_inp", MW'(m_inp), 0);
    checkOutput("reset_res_data", res_data, 0);
    checkOutput("reset_m_high", MW'(m_high), 0);

    $display("[TB] back-to-back pattern frame");
    res_ready = 1'b1;
    for (int i = 0; i < ROWS; i++) applyStimulus(patRow(i), 0);
    cyc = -1; high = 0; first_high = -1;
    for (int n = 1; n <= 50; n++) begin
      tick();
      if (m_high) begin
        high++;
        if (first_high < 0) first_high = n;
      end
      if (res_valid) begin
        cyc = n;
        break;
      end
    end
    checkOutput("latency", MW'(cyc), MW'(SETTLE_CYC + EVAL_CYC));
    checkOutput("m_high_len", MW'(high), MW'(EVAL_CYC));
    checkOutput("m_high_start", MW'(first_high), 1);
    checkOutput("row0_bits", MW'(res_data[COLS-1:0]), MW'({COLS{1'b1}}));
    checkOutput("row1_bits", MW'(res_data[2*COLS-1:COLS]), 0);
    checkOutput("row5_bits", MW'(res_data[6*COLS-1:5*COLS]), MW'({COLS{1'b1}}));
    checkOutput("row7_bits", MW'(res_data[8*COLS-1:7*COLS]), 0);
    res_a = res_data;
    tick();
    checkOutput("res_valid_pulse", MW'(res_valid), 0);

    $display("[TB] gapped pattern frame");
    for (int i = 0; i < ROWS; i++) applyStimulus(patRow(i), 3);
    waitResult(cyc);
    checkOutput("gapped_result", res_data, res_a);
    tick();

    $display("[TB] back-pressure with second frame");
    res_ready = 1'b0;
    for (int i = 0; i < ROWS; i++) applyStimulus(randRow(), int'($urandom_range(0, 2)));
    waitResult(cyc);
    res_b = res_data;
    for (int i = 0; i < ROWS; i++) applyStimulus(randRow(), 0);
    repeat (3) tick();
    checkOutput("bp_m_high", MW'(m_high), 0);
    checkOutput("bp_ready", MW'(s_row_ready), 0);
    checkOutput("bp_res_hold", res_data, res_b);
    res_ready = 1'b1;
    tick();
    checkOutput("bp_eval_start", MW'(m_high), 1);
    waitResult(cyc);
    tick();

    $display("[TB] reset mid-frame");
    for (int i = 0; i < 10; i++) applyStimulus(randRow(), 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("post_reset_busy", MW'(busy), 0);
    checkOutput("post_reset_m_row", MW'(m_row), 0);
    applyStimulus(randRow(), 0);
    checkOutput("first_row_after_reset", MW'(m_row), 0);
    for (int i = 1; i < ROWS; i++) applyStimulus(randRow(), 0);
    waitResult(cyc);
    tick();

    $display("[TB] randomized frames");
    rand_ready = 1'b1;
    for (int f = 0; f < 6; f++) begin
      for (int i = 0; i < ROWS; i++) applyStimulus(randRow(), int'($urandom_range(0, 3)));
    end
    repeat (40) tick();
    rand_ready = 1'b0;
    res_ready = 1'b1;
    repeat (3) tick();

`ifdef MESH_SEQ_FRAME_CNT_EN
    $display("[TB] frame counter");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < ROWS; i++) applyStimulus(randRow(), 0);
      waitResult(cyc);
      tick();
      checkOutput("frame_cnt_step", MW'(frame_cnt), MW'(f + 1));
    end
    fc_chk = 1'b0;
    force dut.frame_cnt_q = 16'hFFFF;
    preload_req = 1'b1;
    tick();
    release dut.frame_cnt_q;
    preload_req = 1'b0;
    tick();
    fc_chk = 1'b1;
    for (int i = 0; i < ROWS; i++) applyStimulus(randRow(), 0);
    waitResult(cyc);
    tick();
    checkOutput("frame_cnt_wrap", MW'(frame_cnt), 0);
`endif

    repeat (2) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mesh_frame_sequencer.md
MESH_FRAME_SEQUENCER -- requirements
Module: mesh_frame_sequencer

Interface
REQ-001 The block SHALL have parameter ROWS, 18, mesh rows per frame.
REQ-002 The block SHALL have parameter COLS, 26, pixels per row.
REQ-003 The block SHALL have parameter BPP, 2, bits per pixel.
REQ-004 The block SHALL have parameter SETTLE_CYC, 1, cycles with m_high low after the last row write.
REQ-005 The block SHALL have parameter EVAL_CYC, 4, cycles from m_high rise to valid mesh output.
REQ-006 The block SHALL have one clock and a synchronous, active-high reset: clk  in  1  rising-edge clock; rst  in  1  synchronous active-high reset.
REQ-007 The block SHALL have s_row_data  in  COLS*BPP (52)  pixel row from source.
REQ-008 The block SHALL have s_row_valid  in  1, and s_row_ready  out  1: row handshake.
REQ-009 The block SHALL have m_inp  out  COLS*BPP (52), m_row  out  5, m_high  out  1: mesh write/evaluate controls.
REQ-010 The block SHALL have m_out  in  ROWS*COLS (468)  mesh result.
REQ-011 The block SHALL have res_data  out  468, res_valid  out  1, res_ready  in  1: result handshake.
REQ-012 The block SHALL have busy  out  1  high when a frame is partially loaded or being evaluated.

Function
REQ-013 The FSM SHALL have states LOAD, SETTLE, EVAL; row_cnt counts 0..ROWS-1, phase_cnt counts SETTLE and EVAL cycles.
REQ-014 In LOAD, s_row_ready SHALL be 1; it SHALL be 0 in SETTLE and EVAL.
REQ-015 On an accepted row (valid & ready), m_inp <= s_row_data and m_row <= row_cnt on the same edge; both are then held until the next accept.
REQ-016 On an accept with row_cnt < ROWS-1, row_cnt SHALL increment; with row_cnt == ROWS-1, row_cnt SHALL clear and the FSM SHALL enter SETTLE with phase_cnt = 0.
REQ-017 The FSM SHALL stay in SETTLE while phase_cnt < SETTLE_CYC-1 or while the result slot is occupied (res_valid & ~res_ready); otherwise it SHALL enter EVAL with phase_cnt = 0.
REQ-018 m_high SHALL be 1 exactly in the EVAL state (EVAL_CYC consecutive cycles) and 0 otherwise.
REQ-019 On the edge ending the EVAL cycle with phase_cnt == EVAL_CYC-1, res_data <= m_out, res_valid <= 1, and the FSM SHALL return to LOAD.
REQ-020 res_valid SHALL clear on the edge where res_valid & res_ready; res_data SHALL stay stable while res_valid & ~res_ready.
REQ-021 Loading of the next frame SHALL proceed in LOAD while a prior result is still pending.
REQ-022 If a result is released (res_ready) and a new result is captured on the same edge, res_valid SHALL stay 1 with the new data; REQ-017 prevents any other overlap.
REQ-023 busy SHALL equal (state != LOAD) | (row_cnt != 0).
REQ-024 Latency SHALL be SETTLE_CYC + EVAL_CYC cycles from the last-row accept edge to res_valid, with no back-pressure (5 at defaults).
REQ-025 s_row_valid deassertion mid-frame SHALL stall LOAD with no timeout and no row loss.

Reset
REQ-026 On rst, the block SHALL go to LOAD with row_cnt = 0, phase_cnt = 0, m_high = 0, m_inp = 0, m_row = 0, res_valid = 0, res_data = 0, and busy = 0.
REQ-027 A reset mid-frame or mid-EVAL SHALL discard partial rows and any pending result; after reset, the first accepted row is row 0.

Configuration
REQ-028 With MESH_SEQ_FRAME_CNT_EN defined, the block SHALL add output frame_cnt  out  16, reset to 0, incremented on each res_valid & res_ready handshake and wrapping 0xFFFF->0.
REQ-029 Without MESH_SEQ_FRAME_CNT_EN, the frame_cnt port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-030 Eighteen back-to-back rows, row i = {26{pattern[i%6]}} with pattern 01,00,10,10,01,11, and res_ready = 1 -> m_row steps 0..17; m_high is high exactly 4 cycles starting 1 cycle after the row-17 accept; res_valid pulses 1 cycle with res_data = the m_out model value.
REQ-031 Gaps of 3 cycles with s_row_valid = 0 between rows -> no m_row skip, m_inp held, and result identical to REQ-030.
REQ-032 Hold res_ready = 0 and stream a second frame -> the second frame loads, the FSM waits in SETTLE with m_high = 0, and res_data keeps frame 1; releasing res_ready causes EVAL to start the next cycle.
REQ-033 Assert rst for 1 cycle after row 9, then send 18 rows -> the first post-reset accept drives m_row = 0, no result from the aborted frame appears, and busy = 0 right after reset.
REQ-034 With MESH_SEQ_FRAME_CNT_EN, run 3 frames with res_ready = 1 -> frame_cnt reads 1, 2, 3; preload via force to 0xFFFF then 1 frame -> frame_cnt = 0.
